// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the pipelined flag ALU and its bench.
//   - ALU_ADD..ALU_MUL : 3-bit operation codes
//   - state_t          : FSM encodings (S_IDLE / S_MUL / S_OUT), exposed on a debug port
//   - FLAG_*           : bit positions inside the packed NZCV flag vector
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_pipe_flags_if.sv
// alu_pipe_flags_if: operand/result bus between operand fetch, the ALU and
// writeback.
//   Request : InValid, InReady, OperA, OperB, ALU_Code
//   Response: OutValid, OutReady, Result, Zero, Negative, Carry, Overflow,
//             Busy, IllegalOp
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and its payload steady until that edge;
// ready may depend combinationally on the opposite side's ready, never on valid.
// modport slave is the ALU side, modport master is the stage driving it.
interface alu_pipe_flags_if #(
  parameter int WIDTH = 32
);
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] OperA;
  logic [WIDTH-1:0] OperB;
  logic [2:0]       ALU_Code;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Negative;
  logic             Carry;
  logic             Overflow;
  logic             Busy;
  logic             IllegalOp;

  modport slave (
    input  InValid, OperA, OperB, ALU_Code, OutReady,
    output InReady, OutValid, Result, Zero, Negative, Carry, Overflow, Busy, IllegalOp
  );

  modport master (
    output InValid, OperA, OperB, ALU_Code, OutReady,
    input  InReady, OutValid, Result, Zero, Negative, Carry, Overflow, Busy, IllegalOp
  );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add unsigned multiplier, one multiplier bit
// per cycle. Only built when ALU_MUL_EN is defined.
//   clk, rst  : clock, synchronous active-high reset (aborts a product)
//   start_i   : capture a_i/b_i and begin; ignored while running
//   a_i, b_i  : operands
//   done_o    : high during the last of WIDTH busy cycles
//   product_o : full 2*WIDTH product, valid while done_o is high
`ifdef ALU_MUL_EN
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);
  localparam int CW = $clog2(WIDTH);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_q;

  // Partial sum for the bit being retired this cycle; on the final cycle it is
  // already the complete product, so it is exported directly.
  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o    = busy_q & (cnt_q == CW'(WIDTH - 1));
  assign product_o = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else if (start_i && !busy_q) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      acc_q    <= '0;
      mplier_q <= b_i;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end
endmodule
`endif

// File: rtl/alu_pipe_flags.sv
// alu_pipe_flags: handshaked ALU with registered Result and NZCV flags.
// Single-cycle ops are ready one cycle after accept; the output register holds
// the result through writeback stalls.
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : operand/op request and result/flag response, see
//                 alu_pipe_flags_if
//   dbg_state_o : current FSM state (state_t encoding)
// Build option ALU_MUL_EN: adds the iterative multiplier (WIDTH busy cycles).
// Without it op 111 completes at once with Result=0, Z=1 and IllegalOp=1.
module alu_pipe_flags
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  alu_pipe_flags_if.slave bus,
  output logic [1:0] dbg_state_o
);
  state_t state_q, state_d;

  logic [WIDTH-1:0]   res_q, res_d;
  logic [3:0]         flags_q, flags_d;
  logic               ill_q, ill_d;
  logic               accept, go_mul, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic               load, c_sel, v_sel;
  logic               in_ready, out_valid, busy;

  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     sum_w, dif_w, shl_w, shr_w;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c, alu_v, alu_ill;

  assign accept = bus.InValid & in_ready;

`ifdef ALU_MUL_EN
  assign go_mul = (bus.ALU_Code == ALU_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (accept & go_mul),
    .a_i       (bus.OperA),
    .b_i       (bus.OperB),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );
`else
  assign go_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  // Single-cycle datapath. The extra top bit of each intermediate carries C;
  // for right shifts a guard bit below the LSB catches the last bit shifted out.
  assign shamt = bus.OperB[SHW-1:0];
  assign sum_w = {1'b0, bus.OperA} + {1'b0, bus.OperB};
  assign dif_w = {1'b0, bus.OperA} + {1'b0, ~bus.OperB} + (WIDTH+1)'(1);
  assign shl_w = {1'b0, bus.OperA} << shamt;
  assign shr_w = {bus.OperA, 1'b0} >> shamt;

  always_comb begin
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (bus.ALU_Code)
      ALU_ADD: begin
        alu_r = sum_w[WIDTH-1:0];
        alu_c = sum_w[WIDTH];
        alu_v = (bus.OperA[WIDTH-1] == bus.OperB[WIDTH-1]) & (alu_r[WIDTH-1] != bus.OperA[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_r = dif_w[WIDTH-1:0];
        alu_c = dif_w[WIDTH];
        alu_v = (bus.OperA[WIDTH-1] != bus.OperB[WIDTH-1]) & (alu_r[WIDTH-1] != bus.OperA[WIDTH-1]);
      end
      ALU_AND: alu_r = bus.OperA & bus.OperB;
      ALU_OR:  alu_r = bus.OperA | bus.OperB;
      ALU_XOR: alu_r = bus.OperA ^ bus.OperB;
      ALU_SHL: begin
        alu_r = shl_w[WIDTH-1:0];
        alu_c = shl_w[WIDTH];
      end
      ALU_SHR: begin
        alu_r = shr_w[WIDTH:1];
        alu_c = shr_w[0];
      end
      // Reached for op 111 only when the multiplier is compiled out.
      default: alu_ill = 1'b1;
    endcase
  end

  // Output register load: multiplier completion or a single-cycle accept.
  // They never coincide because nothing is accepted while in S_MUL.
  always_comb begin
    res_d   = res_q;
    flags_d = flags_q;
    ill_d   = ill_q;
    load    = 1'b0;
    c_sel   = 1'b0;
    v_sel   = 1'b0;
    if (mul_done) begin
      load  = 1'b1;
      res_d = mul_prod[WIDTH-1:0];
      c_sel = |mul_prod[2*WIDTH-1:WIDTH];
      ill_d = 1'b0;
    end else if (accept && !go_mul) begin
      load  = 1'b1;
      res_d = alu_r;
      c_sel = alu_c;
      v_sel = alu_v;
      ill_d = alu_ill;
    end
    if (load) begin
      flags_d[FLAG_N] = res_d[WIDTH-1];
      flags_d[FLAG_Z] = ~|res_d;
      flags_d[FLAG_C] = c_sel;
      flags_d[FLAG_V] = v_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      flags_q <= '0;
      ill_q   <= 1'b0;
    end else begin
      res_q   <= res_d;
      flags_q <= flags_d;
      ill_q   <= ill_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = go_mul ? S_MUL : S_OUT;
      S_MUL:  if (mul_done) state_d = S_OUT;
      S_OUT: begin
        if (bus.OutReady) begin
          if (bus.InValid) state_d = go_mul ? S_MUL : S_OUT;
          else             state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. Ready while draining lets a new op issue back-to-back.
  always_comb begin
    in_ready  = (state_q == S_IDLE) | ((state_q == S_OUT) & bus.OutReady);
    out_valid = (state_q == S_OUT);
`ifdef ALU_MUL_EN
    busy      = (state_q == S_MUL);
`else
    busy      = 1'b0;
`endif
  end

  assign bus.InReady   = in_ready;
  assign bus.OutValid  = out_valid;
  assign bus.Busy      = busy;
  assign bus.Result    = res_q;
  assign bus.Negative  = flags_q[FLAG_N];
  assign bus.Zero      = flags_q[FLAG_Z];
  assign bus.Carry     = flags_q[FLAG_C];
  assign bus.Overflow  = flags_q[FLAG_V];
  assign bus.IllegalOp = ill_q;
  assign dbg_state_o   = state_q;

endmodule
